// File: rtl/wb_regfile.sv
// Write-back stage register file: decodes the W-stage instruction into a single
// write port, holds $1..$31 with same-cycle read bypass, and counts retired instructions.
module wb_regfile (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IR_W,
  input  logic [31:0] PC4_W,
  input  logic [31:0] AO_W,
  input  logic [31:0] DR_W,
  input  logic [31:0] SH_W,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        WE_W,
  output logic [4:0]  WA_W,
  output logic [31:0] WD_W,
  output logic [31:0] Retired
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] link_addr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        wr_sel;
  logic [4:0]  wr_tgt;
  logic [31:0] wr_data;
  logic [31:0] regs [1:31];
  logic [31:0] retired_q;
  logic        unused_ir_bits;

  assign op        = IR_W[31:26];
  assign fn        = IR_W[5:0];
  assign rt        = IR_W[20:16];
  assign rd        = IR_W[15:11];
  assign link_addr = PC4_W + 32'd4;
  assign ld_byte   = DR_W[{AO_W[1:0], 3'b000} +: 8];
  assign ld_half   = DR_W[{AO_W[1], 4'b0000} +: 16];

  // rs and shamt never influence the write-back decision.
  assign unused_ir_bits = ^{IR_W[25:21], IR_W[10:6]};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_sel  = 1'b0;
    wr_tgt  = '0;
    wr_data = '0;
    case (op)
      OP_SPECIAL: begin
        if (fn != FN_JR) begin
          wr_sel = 1'b1;
          wr_tgt = rd;
          if (fn == FN_MFHI || fn == FN_MFLO) wr_data = SH_W;
          else if (fn == FN_JALR)              wr_data = link_addr;
          else                                 wr_data = AO_W;
        end
      end
      OP_JAL: begin
        wr_sel  = 1'b1;
        wr_tgt  = 5'd31;
        wr_data = link_addr;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        wr_sel  = 1'b1;
        wr_tgt  = rt;
        wr_data = AO_W;
      end
      OP_LW: begin
        wr_sel  = 1'b1;
        wr_tgt  = rt;
        wr_data = DR_W;
      end
      OP_LB, OP_LBU: begin
        wr_sel  = 1'b1;
        wr_tgt  = rt;
        wr_data = {{24{ld_byte[7] & (op == OP_LB)}}, ld_byte};
      end
      OP_LH, OP_LHU: begin
        wr_sel  = 1'b1;
        wr_tgt  = rt;
        wr_data = {{16{ld_half[15] & (op == OP_LH)}}, ld_half};
      end
      default: ;
    endcase
  end

  // A write to $0 still shows its target and data, but never asserts the enable.
  assign WE_W = wr_sel && (wr_tgt != 5'd0);
  assign WA_W = wr_tgt;
  assign WD_W = wr_data;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      // NOTE: the whole array is cleared by reset, because every register must read 0 the moment reset is applied.
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (WE_W) begin
      // NOTE: sequential state is updated with non-blocking assignments only, so every always_ff sees pre-edge values.
      regs[WA_W] <= WD_W;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)              retired_q <= '0;
    else if (IR_W != 32'd0)  retired_q <= retired_q + 32'd1;
  end

  assign Retired = retired_q;

  // Reads bypass the pending write so a consumer in the same cycle sees the new value.
  assign RD1 = (A1 == 5'd0)               ? 32'd0 :
               (WE_W && (A1 == WA_W))     ? WD_W  : regs[A1];
  assign RD2 = (A2 == 5'd0)               ? 32'd0 :
               (WE_W && (A2 == WA_W))     ? WD_W  : regs[A2];

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: Clk is the single clock, and Reset is asynchronous and active-low.
REQ-002 Ports SHALL be, clock and reset first:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low
- IR_W  in  32  W-stage instruction
- PC4_W  in  32  W-stage PC+4
- AO_W  in  32  ALU result / load address
- DR_W  in  32  raw data-memory word
- SH_W  in  32  HI/LO read value (mfhi/mflo)
- A1, A2  in  5  read addresses
- RD1, RD2  out  32  read data
- WE_W  out  1  write enable this cycle
- WA_W  out  5  write address this cycle
- WD_W  out  32  write data this cycle
- Retired  out  32  retired-instruction count

Function
REQ-003 Storage SHALL be 31 x 32-bit registers $1..$31; $0 SHALL read 0 and SHALL never be written.
REQ-004 Decode SHALL be combinational from IR_W. op = IR_W[31:26], fn = IR_W[5:0], rt = IR_W[20:16], rd = IR_W[15:11].
REQ-005 op=0x00 SHALL select the write target by fn:
- fn=0x10 or 0x12: rd <- SH_W
- fn=0x09 (jalr): rd <- PC4_W+4
- fn=0x08 (jr): no write
- any other fn: rd <- AO_W
REQ-006 I-type ALU ops (op 0x08, 0x09, 0x0A, 0x0B, 0x0C, 0x0D, 0x0E, 0x0F) SHALL write rt <- AO_W.
REQ-007 op=0x03 (jal) SHALL write $31 <- PC4_W+4; the add SHALL be modulo 2^32.
REQ-008 Load ops SHALL write to rt as follows:
- lw (0x23): DR_W; AO_W[1:0] ignored
- lb (0x20) / lbu (0x24): byte DR_W[8*AO_W[1:0]+:8], sign- / zero-extended
- lh (0x21) / lhu (0x25): half DR_W[16*AO_W[1]+:16], sign- / zero-extended; AO_W[0] ignored
REQ-009 All other opcodes SHALL perform no write.
REQ-010 WE_W SHALL be 1 only when REQ-005..008 select a write and the target is nonzero. WA_W and WD_W SHALL show target and data whenever a write is selected; otherwise both SHALL be 0.
REQ-011 When WE_W=1, the register write SHALL occur at the rising edge of Clk, so the write latency is 1 edge.
REQ-012 RD1 and RD2 SHALL be combinational reads.
- Ax=0 SHALL return 0.
- Ax=WA_W with WE_W=1 SHALL return WD_W (same-cycle bypass).
- Otherwise the stored value SHALL be returned.
REQ-013 Simultaneous reads SHALL be supported: A1=A2 SHALL give RD1=RD2, including under bypass.
REQ-014 Retired SHALL increment by 1 at each rising edge where IR_W != 0, whether or not a write occurs. It SHALL wrap from 0xFFFFFFFF to 0. IR_W=0 (nop bubble) SHALL NOT count.

Reset
REQ-015 While Reset=0, all of $1..$31 and Retired SHALL be 0 immediately, regardless of Clk.
REQ-016 Reset asserted during a write edge SHALL win: no write and no count occur.
REQ-017 RD1/RD2/WE_W/WA_W/WD_W SHALL stay combinational during reset and reflect IR_W and the zeroed array.
REQ-018 The first write SHALL be accepted at the first rising edge after Reset returns to 1.

Verification
REQ-019 IR_W=ori $5,$0,0x1234 with AO_W=0x00001234; edge; A1=5 -> RD1=0x00001234; Retired=1.
REQ-020 IR_W=lb $7 with AO_W[1:0]=2, DR_W=0x11802233 -> WD_W=0xFFFFFF80. Same with lhu and AO_W[1]=1 -> WD_W=0x00001180.
REQ-021 jal with PC4_W=0x00003004 -> WA_W=31, WD_W=0x00003008. Same cycle, A2=31 -> RD2=0x00003008 via bypass, before the edge.
REQ-022 addu $0,... with AO_W=0xDEADBEEF -> WE_W=0 and RD1(A1=0)=0 after the edge; Retired still increments.
REQ-023 Write $9=0xA5A5A5A5, then pulse Reset low mid-cycle with no clock -> RD1(A1=9)=0 and Retired=0 at once.
REQ-024 Preload Retired to 0xFFFFFFFE via 2 counts short of wrap by force, then apply 2 non-nop edges -> Retired=0x00000000.
